// File: rtl/bootrom_arbiter.sv
// Round-robin arbiter sharing a single-port synchronous boot ROM between N TCDM masters.
// Writes and out-of-range word indices return an error response without touching the ROM.

module bootrom_arbiter_lane #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  sel,
  input  logic                  err,
  input  logic [DATA_WIDTH-1:0] q,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err_flag
);
  assign rvalid   = sel;
  assign err_flag = sel & err;
  assign rdata    = (sel && !err) ? q : '0;
endmodule

module bootrom_arbiter #(
  parameter int unsigned N_MASTERS      = 2,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ROM_ADDR_WIDTH = 10,
  parameter int unsigned ROM_WORDS      = 1024
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [N_MASTERS-1:0]                 req_i,
  input  logic [N_MASTERS-1:0]                 we_i,
  input  logic [N_MASTERS-1:0][ADDR_WIDTH-1:0] addr_i,
  output logic [N_MASTERS-1:0]                 gnt_o,
  output logic [N_MASTERS-1:0]                 rvalid_o,
  output logic [N_MASTERS-1:0][DATA_WIDTH-1:0] rdata_o,
  output logic [N_MASTERS-1:0]                 err_o,
  output logic                                 rom_cen_o,
  output logic [ROM_ADDR_WIDTH-1:0]            rom_addr_o,
  input  logic [DATA_WIDTH-1:0]                rom_q_i
);
  localparam int unsigned IDX_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int unsigned WIDX_W = ADDR_WIDTH - 2;
  localparam logic [WIDX_W:0] ROM_LIMIT = (WIDX_W+1)'(ROM_WORDS);

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] id;
    logic             err;
  } rsp_t;

  logic [IDX_W-1:0]  rr_ptr, rr_nxt, m, cand;
  logic              hit, acc_err;
  logic [WIDX_W-1:0] widx;
  rsp_t              rsp;

  // First requester at or after rr_ptr, wrapping modulo N_MASTERS.
  always_comb begin
    hit  = 1'b0;
    m    = '0;
    cand = '0;
    for (int unsigned off = 0; off < N_MASTERS; off++) begin
      cand = IDX_W'((32'(rr_ptr) + off) % N_MASTERS);
      if (!hit && req_i[cand]) begin
        hit = 1'b1;
        m   = cand;
      end
    end
  end

  assign gnt_o   = hit ? (N_MASTERS'(1) << m) : '0;
  assign widx    = addr_i[m][ADDR_WIDTH-1:2];
  assign acc_err = we_i[m] | ({1'b0, widx} >= ROM_LIMIT);
  assign rr_nxt  = (32'(m) == N_MASTERS - 1) ? '0 : m + 1'b1;

  assign rom_cen_o  = !(hit && !acc_err);
  assign rom_addr_o = rom_cen_o ? '0 : widx[ROM_ADDR_WIDTH-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr <= '0;
      rsp    <= '0;
    end else begin
      if (hit) rr_ptr <= rr_nxt;
      rsp <= '{vld: hit, id: m, err: acc_err};
    end
  end

  // Response fans out to one lane per master; only the granted id sees it.
  for (genvar g = 0; g < N_MASTERS; g++) begin : g_lane
    bootrom_arbiter_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .sel      (rsp.vld && (rsp.id == IDX_W'(g))),
      .err      (rsp.err),
      .q        (rom_q_i),
      .rvalid   (rvalid_o[g]),
      .rdata    (rdata_o[g]),
      .err_flag (err_o[g])
    );
  end
endmodule
